// File: rtl/base_arbmux.sv
// Round-robin, packet-aware arbitrating multiplexer with a registered output stage.
// Once a way wins it keeps the output until it delivers its end-of-packet beat.
module base_arbmux #(
  parameter int ways  = 2,
  parameter int width = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [0:ways-1]       i_v,
  output logic [0:ways-1]       i_r,
  input  logic [0:ways*width-1] i_d,
  input  logic [0:ways-1]       i_e,
  output logic                  o_v,
  input  logic                  o_r,
  output logic [0:width-1]      o_d,
  output logic                  o_e,
  output logic [0:ways-1]       o_sel
);

  localparam int              pw       = (ways > 1) ? $clog2(ways) : 1;
  localparam logic [pw:0]     ways_w   = (pw+1)'(ways);
  localparam logic [pw-1:0]   last_way = pw'(ways - 1);

  // arbitration state
  logic [pw-1:0] ptr_reg, ptr_next;
  logic [pw-1:0] lock_way_reg, lock_way_next;
  logic          lock_reg, lock_next;

  // output register
  logic             o_v_reg;
  logic [0:width-1] o_d_reg;
  logic             o_e_reg;
  logic [0:ways-1]  o_sel_reg;

  logic [0:width-1] way_d [ways];
  logic [pw-1:0]    grant_idx;
  logic             grant_any;
  logic [0:ways-1]  grant;
  logic [pw:0]      cand;
  logic             load;
  logic             accept;

  assign load   = ~o_v_reg | o_r;
  assign accept = load & grant_any;

  genvar gi;
  generate
    for (gi = 0; gi < ways; gi++) begin : g_way
      assign way_d[gi] = i_d[gi*width +: width];
      assign grant[gi] = grant_any & (grant_idx == pw'(gi));
      // gated by reset so no way sees a handshake while the block is held in reset
      assign i_r[gi]   = reset_n & load & grant[gi];
    end
  endgenerate

  // Rotating priority search starting at ptr; a lock overrides the search entirely.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (lock_reg) begin
      grant_any = i_v[lock_way_reg];
      grant_idx = lock_way_reg;
    end else begin
      for (int i = 0; i < ways; i++) begin
        cand = {1'b0, ptr_reg} + (pw+1)'(i);
        if (cand >= ways_w) begin
          cand = cand - ways_w;
        end
        if (!grant_any && i_v[cand[pw-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = cand[pw-1:0];
        end
      end
    end
  end

  always_comb begin
    ptr_next      = ptr_reg;
    lock_next     = lock_reg;
    lock_way_next = lock_way_reg;
    if (accept) begin
      if (i_e[grant_idx]) begin
        lock_next = 1'b0;
        ptr_next  = (grant_idx == last_way) ? '0 : grant_idx + pw'(1);
      end else begin
        lock_next     = 1'b1;
        lock_way_next = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_reg      <= '0;
      lock_reg     <= 1'b0;
      lock_way_reg <= '0;
    end else begin
      ptr_reg      <= ptr_next;
      lock_reg     <= lock_next;
      lock_way_reg <= lock_way_next;
    end
  end

  // Payload only changes on a capture, so it stays put while the beat is stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_v_reg   <= 1'b0;
      o_d_reg   <= '0;
      o_e_reg   <= 1'b0;
      o_sel_reg <= '0;
    end else if (load) begin
      o_v_reg <= grant_any;
      if (grant_any) begin
        o_d_reg   <= way_d[grant_idx];
        o_e_reg   <= i_e[grant_idx];
        o_sel_reg <= grant;
      end
    end
  end

  assign o_v   = o_v_reg;
  assign o_d   = o_d_reg;
  assign o_e   = o_e_reg;
  assign o_sel = o_sel_reg;

endmodule

// File: tb/tb_base_arbmux.sv
// Scoreboard bench for base_arbmux: a 2-way and a 4-way instance fed by table-driven
// sources, with expected output beats queued per instance and checked by monitors.
module tb_base_arbmux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic o_r;

  logic [0:1]  i_v2, i_r2, i_e2;
  logic [0:15] i_d2;
  logic        o_v2, o_e2;
  logic [0:7]  o_d2;
  logic [0:1]  o_sel2;

  logic [0:3]  i_v4, i_r4, i_e4;
  logic [0:31] i_d4;
  logic        o_v4, o_e4;
  logic [0:7]  o_d4;
  logic [0:3]  o_sel4;

  base_arbmux #(.ways(2), .width(8)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .i_v(i_v2), .i_r(i_r2), .i_d(i_d2), .i_e(i_e2),
    .o_v(o_v2), .o_r(o_r), .o_d(o_d2), .o_e(o_e2), .o_sel(o_sel2)
  );

  base_arbmux #(.ways(4), .width(8)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .i_v(i_v4), .i_r(i_r4), .i_d(i_d4), .i_e(i_e4),
    .o_v(o_v4), .o_r(o_r), .o_d(o_d4), .o_e(o_e4), .o_sel(o_sel4)
  );

  typedef struct packed {
    logic [0:3] sel;
    logic [7:0] d;
    logic       e;
  } exp_t;

  exp_t exp2_q[$];
  exp_t exp4_q[$];
  exp_t ex2, ex4;

  int vectors = 0;
  int miscompares = 0;

  // source tables: [dut][way][beat], dut 0 = 2-way, dut 1 = 4-way
  logic [7:0] bd [2][4][16];
  logic       be [2][4][16];
  int         bg [2][4][16];
  int         bn [2][4];
  int         bi [2][4];
  int         gc [2][4];
  logic [0:1] acc2;
  logic [0:3] acc4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic clear_src();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++) begin
        bn[d][k] = 0;
        bi[d][k] = 0;
        gc[d][k] = 0;
      end
  endtask

  task automatic add(input int d, input int k, input logic [7:0] data, input logic e, input int g);
    if (bi[d][k] == bn[d][k]) gc[d][k] = g;
    bd[d][k][bn[d][k]] = data;
    be[d][k][bn[d][k]] = e;
    bg[d][k][bn[d][k]] = g;
    bn[d][k]++;
  endtask

  task automatic push2(input logic [0:1] sel, input logic [7:0] d, input logic e);
    exp_t x;
    x.sel = {sel, 2'b00};
    x.d   = d;
    x.e   = e;
    exp2_q.push_back(x);
  endtask

  task automatic push4(input logic [0:3] sel, input logic [7:0] d, input logic e);
    exp_t x;
    x.sel = sel;
    x.d   = d;
    x.e   = e;
    exp4_q.push_back(x);
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < 2; k++) begin
      i_v2[k] = 1'b0;
      if (bi[0][k] < bn[0][k]) begin
        if (gc[0][k] > 0) gc[0][k]--;
        else begin
          i_v2[k]         = 1'b1;
          i_d2[k*8 +: 8]  = bd[0][k][bi[0][k]];
          i_e2[k]         = be[0][k][bi[0][k]];
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      i_v4[k] = 1'b0;
      if (bi[1][k] < bn[1][k]) begin
        if (gc[1][k] > 0) gc[1][k]--;
        else begin
          i_v4[k]         = 1'b1;
          i_d4[k*8 +: 8]  = bd[1][k][bi[1][k]];
          i_e4[k]         = be[1][k][bi[1][k]];
        end
      end
    end
  endtask

  // source driver: handshakes sampled mid-cycle, advanced just after the edge
  always begin
    @(negedge clk);
    acc2 = i_v2 & i_r2;
    acc4 = i_v4 & i_r4;
    @(posedge clk);
    #2;
    for (int k = 0; k < 2; k++)
      if (acc2[k]) begin
        bi[0][k]++;
        if (bi[0][k] < bn[0][k]) gc[0][k] = bg[0][k][bi[0][k]];
      end
    for (int k = 0; k < 4; k++)
      if (acc4[k]) begin
        bi[1][k]++;
        if (bi[1][k] < bn[1][k]) gc[1][k] = bg[1][k][bi[1][k]];
      end
    drive_inputs();
  end

  always @(negedge clk) begin
    if (reset_n && o_v2 && o_r) begin
      vectors++;
      if (exp2_q.size() == 0) begin
        miscompares++;
        $display("FAIL d2_unexpected: got sel=%b d=%h e=%b, expected no beat", o_sel2, o_d2, o_e2);
      end else begin
        ex2 = exp2_q.pop_front();
        if ({o_sel2, 2'b00} !== ex2.sel || o_d2 !== ex2.d || o_e2 !== ex2.e) begin
          miscompares++;
          $display("FAIL d2_beat: got sel=%b d=%h e=%b, expected sel=%b d=%h e=%b",
                   o_sel2, o_d2, o_e2, ex2.sel[0:1], ex2.d, ex2.e);
        end else
          $display("d2 beat sel=%b d=%h e=%b ok", o_sel2, o_d2, o_e2);
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && o_v4 && o_r) begin
      vectors++;
      if (exp4_q.size() == 0) begin
        miscompares++;
        $display("FAIL d4_unexpected: got sel=%b d=%h e=%b, expected no beat", o_sel4, o_d4, o_e4);
      end else begin
        ex4 = exp4_q.pop_front();
        if (o_sel4 !== ex4.sel || o_d4 !== ex4.d || o_e4 !== ex4.e) begin
          miscompares++;
          $display("FAIL d4_beat: got sel=%b d=%h e=%b, expected sel=%b d=%h e=%b",
                   o_sel4, o_d4, o_e4, ex4.sel, ex4.d, ex4.e);
        end else
          $display("d4 beat sel=%b d=%h e=%b ok", o_sel4, o_d4, o_e4);
      end
    end
  end

  function automatic bit src_busy();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++)
        if (bi[d][k] < bn[d][k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n = 0;
    while ((exp2_q.size() != 0 || exp4_q.size() != 0 || src_busy()) && n < bound) begin
      tick();
      n++;
    end
    if (n >= bound) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_drain: got %0d/%0d beats pending after %0d cycles, expected 0",
               name, exp2_q.size(), exp4_q.size(), bound);
    end
    tick();
  endtask

  task automatic wait_ov(input string name, input bit four);
    int n = 0;
    while (((four ? o_v4 : o_v2) !== 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_wait: got o_v=0 for 50 cycles, expected o_v=1", name);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    o_r     = 1'b1;
    i_v2 = '0; i_e2 = '0; i_d2 = '0;
    i_v4 = '0; i_e4 = '0; i_d4 = '0;
    acc2 = '0; acc4 = '0;
    clear_src();

    // reset held with inputs valid and o_r high
    add(0, 0, 8'h01, 1'b1, 0);
    add(0, 1, 8'h02, 1'b1, 0);
    push2(2'b10, 8'h01, 1'b1);
    push2(2'b01, 8'h02, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_o_v", o_v2, 1'b0);
      chk("rst_o_sel", o_sel2, 2'b00);
      chk("rst_o_d", o_d2, 8'h00);
      chk("rst_i_r", i_r2, 2'b00);
    end
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("first_grant_i_r", i_r2, 2'b10);
    wait_drain("reset", 40);

    // round robin across 4 ways, single-beat packets
    for (int k = 0; k < 4; k++) begin
      add(1, k, 8'h40 + 8'(k), 1'b1, 0);
      add(1, k, 8'h50 + 8'(k), 1'b1, 0);
    end
    push4(4'b1000, 8'h40, 1'b1); push4(4'b0100, 8'h41, 1'b1);
    push4(4'b0010, 8'h42, 1'b1); push4(4'b0001, 8'h43, 1'b1);
    push4(4'b1000, 8'h50, 1'b1); push4(4'b0100, 8'h51, 1'b1);
    push4(4'b0010, 8'h52, 1'b1); push4(4'b0001, 8'h53, 1'b1);
    wait_ov("rr", 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("rr_throughput_o_v", o_v4, 1'b1);
      @(negedge clk);
    end
    wait_drain("rr", 40);

    // packet lock: way 1 holds the output through a 2-cycle idle gap
    add(0, 1, 8'h11, 1'b0, 0);
    add(0, 1, 8'h12, 1'b0, 2);
    add(0, 1, 8'h13, 1'b1, 0);
    add(0, 0, 8'hA0, 1'b1, 1);
    push2(2'b01, 8'h11, 1'b0);
    push2(2'b01, 8'h12, 1'b0);
    push2(2'b01, 8'h13, 1'b1);
    push2(2'b10, 8'hA0, 1'b1);
    wait_drain("lock", 40);

    // backpressure: 0x55 stalls for 5 cycles
    o_r = 1'b0;
    add(0, 1, 8'h55, 1'b1, 0);
    add(0, 1, 8'h57, 1'b1, 0);
    add(0, 0, 8'h66, 1'b1, 0);
    push2(2'b01, 8'h55, 1'b1);
    push2(2'b10, 8'h66, 1'b1);
    push2(2'b01, 8'h57, 1'b1);
    wait_ov("bp", 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_o_d", o_d2, 8'h55);
      chk("bp_o_v", o_v2, 1'b1);
      chk("bp_i_r", i_r2, 2'b00);
      @(negedge clk);
    end
    tick();
    o_r = 1'b1;
    wait_drain("bp", 40);

    // idle gaps: way 2 on alternate cycles
    add(1, 2, 8'h21, 1'b1, 0);
    add(1, 2, 8'h22, 1'b1, 1);
    add(1, 2, 8'h23, 1'b1, 1);
    add(1, 2, 8'h24, 1'b1, 1);
    for (int i = 0; i < 4; i++) push4(4'b0010, 8'h21 + 8'(i), 1'b1);
    wait_ov("gap", 1'b1);
    for (int i = 0; i < 7; i++) begin
      chk("gap_o_v", o_v4, (i % 2 == 0) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    wait_drain("gap", 40);

    // reset in the middle of a 3-beat packet from way 1
    add(0, 1, 8'h31, 1'b0, 0);
    add(0, 1, 8'h32, 1'b0, 0);
    add(0, 1, 8'h33, 1'b1, 0);
    push2(2'b01, 8'h31, 1'b0);
    wait_ov("midrst", 1'b0);
    tick();
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_o_v", o_v2, 1'b0);
    tick();
    clear_src();
    add(0, 0, 8'h40, 1'b1, 0);
    add(0, 1, 8'h41, 1'b1, 0);
    push2(2'b10, 8'h40, 1'b1);
    push2(2'b01, 8'h41, 1'b1);
    tick();
    tick();
    reset_n = 1'b1;
    wait_drain("midrst", 40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
